// File: rtl/pic_int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pic_int_ctrl_if
// Brief    : Register bus, interrupt sources and CPU handshake for pic_int_ctrl.
// Revision : 1.0
// ============================================================================
interface pic_int_ctrl_if #(
   parameter int N_SRC = 4,
   parameter int PC_W  = 11
);
   logic [N_SRC-1:0] src_in;
   logic             reg_we;
   logic [2:0]       reg_addr;
   logic [7:0]       reg_wdata;
   logic [7:0]       reg_rdata;
   logic             irq_req;
   logic             irq_ack;
   logic             retfie;
   logic [PC_W-1:0]  vec_addr;
   logic [2:0]       vec_id;
   logic             wake;

   // CPU / peripheral side
   modport master (
      output src_in, reg_we, reg_addr, reg_wdata, irq_ack, retfie,
      input  reg_rdata, irq_req, vec_addr, vec_id, wake
   );

   // Interrupt controller side
   modport slave (
      input  src_in, reg_we, reg_addr, reg_wdata, irq_ack, retfie,
      output reg_rdata, irq_req, vec_addr, vec_id, wake
   );
endinterface
`default_nettype wire

// File: rtl/pic_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pic_int_ctrl
// Brief    : Edge-detected, fixed-priority interrupt controller with
//            req/ack/retfie CPU handshake. Optional macro PIC_INT_SYNC_EN
//            adds a 2-flop input synchroniser per source.
// Revision : 1.0
// ============================================================================
module pic_int_ctrl #(
   parameter int              N_SRC    = 4,
   parameter logic [7:0]      EDGE_POL = 8'hFF,
   parameter int              PC_W     = 11,
   parameter logic [PC_W-1:0] VEC_BASE = PC_W'(11'h004)
) (
   input  wire logic   clk,
   input  wire logic   rst,
   pic_int_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_gie;
   logic             r_peie;
   logic [N_SRC-1:0] r_ie;
   logic [N_SRC-1:0] r_if;
   logic [N_SRC-1:0] r_ovf;
   logic [N_SRC-1:0] r_prev;
   logic [2:0]       r_vec_id;
   logic             r_irq_req;

   logic [N_SRC-1:0] w_src;
   logic [N_SRC-1:0] w_event;
   logic [N_SRC-1:0] w_act;
   logic [N_SRC-1:0] w_wdata;
   logic             w_pending;
   logic             w_ack_ok;
   logic [2:0]       w_prio;
   logic             w_wr_con;
   logic             w_wr_ie;
   logic             w_wr_if;
   logic             w_wr_ovf;
   logic [7:0]       w_rdata;

`ifdef PIC_INT_SYNC_EN
   // Arming waits for the synchroniser to fill so released reset never looks like an edge
   localparam int ARM_W = 3;
   logic [N_SRC-1:0] r_sync1;
   logic [N_SRC-1:0] r_sync2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= bus.src_in;
         r_sync2 <= r_sync1;
      end
   end
   assign w_src = r_sync2;
`else
   localparam int ARM_W = 1;
   assign w_src = bus.src_in;
`endif

   logic [ARM_W-1:0] r_arm;

   // Edge = source now at its active level and was not last cycle
   assign w_event = r_arm[ARM_W-1]
                  ? (~(w_src ^ EDGE_POL[N_SRC-1:0]) & (r_prev ^ EDGE_POL[N_SRC-1:0]))
                  : '0;

   assign w_wdata   = bus.reg_wdata[N_SRC-1:0];
   assign w_wr_con  = bus.reg_we && (bus.reg_addr == 3'd0);
   assign w_wr_ie   = bus.reg_we && (bus.reg_addr == 3'd1);
   assign w_wr_if   = bus.reg_we && (bus.reg_addr == 3'd2);
   assign w_wr_ovf  = bus.reg_we && (bus.reg_addr == 3'd3);
   assign w_act     = r_ie & r_if;
   assign w_pending = r_gie & (|w_act);

   always_comb begin
      w_prio = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_act[i]) w_prio = 3'(i);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ack_ok    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pending) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (bus.irq_ack) begin
               w_state_nxt = S_SERVICE;
               w_ack_ok    = 1'b1;
            end else if (!w_pending) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SERVICE: begin
            if (bus.retfie) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_irq_req <= 1'b0;
         r_arm     <= '0;
         r_prev    <= '0;
         r_vec_id  <= 3'd0;
         r_gie     <= 1'b0;
         r_peie    <= 1'b0;
         r_ie      <= '0;
         r_if      <= '0;
         r_ovf     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_irq_req <= (w_state_nxt == S_REQ);
         r_arm     <= ARM_W'({r_arm, 1'b1});
         r_prev    <= w_src;
         if (w_ack_ok) r_vec_id <= w_prio;
         // Ack clear outranks retfie, which outranks a software CON write
         if (w_ack_ok)        r_gie <= 1'b0;
         else if (bus.retfie) r_gie <= 1'b1;
         else if (w_wr_con)   r_gie <= bus.reg_wdata[7];
         if (w_wr_con) r_peie <= bus.reg_wdata[6];
         if (w_wr_ie)  r_ie   <= w_wdata;
         r_if  <= w_event | (w_wr_if ? w_wdata : r_if);
         r_ovf <= (w_event & r_if) | (w_wr_ovf ? (r_ovf & w_wdata) : r_ovf);
      end
   end

   always_comb begin
      w_rdata = 8'h00;
      case (bus.reg_addr)
         3'd0:    w_rdata = {r_gie, r_peie, 6'b0};
         3'd1:    w_rdata = 8'(r_ie);
         3'd2:    w_rdata = 8'(r_if);
         3'd3:    w_rdata = 8'(r_ovf);
         3'd4:    w_rdata = {5'b0, r_vec_id};
         default: w_rdata = 8'h00;
      endcase
   end

   assign bus.reg_rdata = w_rdata;
   assign bus.irq_req   = r_irq_req;
   assign bus.vec_addr  = VEC_BASE;
   assign bus.vec_id    = r_vec_id;
   assign bus.wake      = |w_act;

endmodule
`default_nettype wire

// File: tb/tb_pic_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_int_ctrl
// Brief    : Directed self-checking bench for pic_int_ctrl (rising and
//            falling polarity instances).
// Revision : 1.0
// ============================================================================
module tb_pic_int_ctrl;

   localparam int N = 4;
`ifdef PIC_INT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pic_int_ctrl_if #(.N_SRC(N), .PC_W(11)) ifc ();
   pic_int_ctrl_if #(.N_SRC(N), .PC_W(11)) ifc2 ();

   pic_int_ctrl #(.N_SRC(N), .EDGE_POL(8'hFF), .PC_W(11), .VEC_BASE(11'h004)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   pic_int_ctrl #(.N_SRC(N), .EDGE_POL(8'hFE), .PC_W(11), .VEC_BASE(11'h004)) dut_fall (
      .clk (clk),
      .rst (rst),
      .bus (ifc2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      ifc.reg_we    = 1'b1;
      ifc.reg_addr  = a;
      ifc.reg_wdata = d;
      tick();
      ifc.reg_we    = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
      ifc.reg_addr = a;
      #1;
      check(tag, {8'h00, ifc.reg_rdata}, {8'h00, exp});
   endtask

   task automatic ack();
      ifc.irq_ack = 1'b1;
      tick();
      ifc.irq_ack = 1'b0;
   endtask

   task automatic ret();
      ifc.retfie = 1'b1;
      tick();
      ifc.retfie = 1'b0;
   endtask

   initial begin
      rst            = 1'b0;
      ifc.src_in     = '0;
      ifc.reg_we     = 1'b0;
      ifc.reg_addr   = 3'd0;
      ifc.reg_wdata  = 8'h00;
      ifc.irq_ack    = 1'b0;
      ifc.retfie     = 1'b0;
      ifc2.src_in    = 4'b0001;
      ifc2.reg_we    = 1'b0;
      ifc2.reg_addr  = 3'd2;
      ifc2.reg_wdata = 8'h00;
      ifc2.irq_ack   = 1'b0;
      ifc2.retfie    = 1'b0;
      repeat (2) tick();

      // Reset state
      rd("rst_con", 3'd0, 8'h00);
      rd("rst_ie",  3'd1, 8'h00);
      rd("rst_if",  3'd2, 8'h00);
      rd("rst_ovf", 3'd3, 8'h00);
      rd("rst_vec", 3'd4, 8'h00);
      check("rst_irq_req",  {15'h0, ifc.irq_req}, 16'h0);
      check("rst_wake",     {15'h0, ifc.wake},    16'h0);
      check("rst_vec_addr", {5'h0, ifc.vec_addr}, 16'h0004);
      rst = 1'b1;
      repeat (2) tick();

      // retfie outside SERVICE only sets GIE
      ret();
      rd("retfie_idle_gie", 3'd0, 8'h80);

      // Basic request / ack
      wr(3'd1, 8'h05);
      wr(3'd0, 8'h80);
      rd("t1_ie",  3'd1, 8'h05);
      rd("t1_con", 3'd0, 8'h80);
      ifc.src_in = 4'b0100;
      tick();
      rd("t1_if", 3'd2, 8'h04);
      check("t1_req_lag", {15'h0, ifc.irq_req}, 16'h0);
      tick();
      check("t1_req", {15'h0, ifc.irq_req}, 16'h1);
      ack();
      check("t1_vec_id",  {13'h0, ifc.vec_id}, 16'h2);
      check("t1_req_off", {15'h0, ifc.irq_req}, 16'h0);
      rd("t1_con_ack", 3'd0, 8'h00);
      rd("t1_vec_reg", 3'd4, 8'h02);
      wr(3'd2, 8'h00);
      ret();
      rd("t1_con_ret", 3'd0, 8'h80);
      tick();
      check("t1_idle_after_ret", {15'h0, ifc.irq_req}, 16'h0);
      ifc.src_in = 4'b0000;
      tick();

      // Simultaneous sources, priority and re-request after retfie
      ifc.src_in = 4'b0101;
      tick();
      rd("t2_if", 3'd2, 8'h05);
      tick();
      check("t2_req", {15'h0, ifc.irq_req}, 16'h1);
      ack();
      check("t2_vec_id0", {13'h0, ifc.vec_id}, 16'h0);
      wr(3'd2, 8'h04);
      wr(3'd0, 8'h80);
      tick();
      check("t2_service_no_rearm", {15'h0, ifc.irq_req}, 16'h0);
      ret();
      rd("t2_con_ret", 3'd0, 8'h80);
      check("t2_req_lag", {15'h0, ifc.irq_req}, 16'h0);
      tick();
      check("t2_req_again", {15'h0, ifc.irq_req}, 16'h1);
      ack();
      check("t2_vec_id2", {13'h0, ifc.vec_id}, 16'h2);
      wr(3'd2, 8'h00);
      ret();
      ifc.src_in = 4'b0000;
      tick();

      // Overflow and hardware-set priority over software clear
      ifc.src_in = 4'b0010;
      tick();
      rd("t3_if_first", 3'd2, 8'h02);
      ifc.src_in = 4'b0000;
      tick();
      ifc.src_in = 4'b0010;
      tick();
      rd("t3_ovf", 3'd3, 8'h02);
      check("t3_no_req", {15'h0, ifc.irq_req}, 16'h0);
      wr(3'd2, 8'h00);
      rd("t3_if_clr", 3'd2, 8'h00);
      ifc.src_in = 4'b0000;
      tick();
      ifc.src_in = 4'b0010;
      wr(3'd2, 8'h00);
      rd("t3_hw_wins", 3'd2, 8'h02);
      rd("t3_ovf_hold", 3'd3, 8'h02);
      wr(3'd3, 8'h00);
      rd("t3_ovf_clr", 3'd3, 8'h00);
      wr(3'd2, 8'h00);
      ifc.src_in = 4'b0000;
      tick();

      // Request withdrawn by GIE clear; stray ack ignored
      ifc.src_in = 4'b0001;
      repeat (2) tick();
      check("t4_req", {15'h0, ifc.irq_req}, 16'h1);
      wr(3'd0, 8'h00);
      tick();
      check("t4_drop", {15'h0, ifc.irq_req}, 16'h0);
      ack();
      check("t4_vec_hold", {13'h0, ifc.vec_id}, 16'h2);
      check("t4_no_req",   {15'h0, ifc.irq_req}, 16'h0);

      // Wake without GIE, then asynchronous reset mid-request
      wr(3'd2, 8'h00);
      check("t5_wake_off", {15'h0, ifc.wake}, 16'h0);
      wr(3'd1, 8'h08);
      ifc.src_in = 4'b1001;
      tick();
      check("t5_wake", {15'h0, ifc.wake}, 16'h1);
      rd("t5_if", 3'd2, 8'h08);
      tick();
      check("t5_no_req", {15'h0, ifc.irq_req}, 16'h0);
      wr(3'd0, 8'h80);
      tick();
      check("t5_in_req", {15'h0, ifc.irq_req}, 16'h1);
      #1 rst = 1'b0;
      #1;
      check("t5_async_req",    {15'h0, ifc.irq_req}, 16'h0);
      check("t5_async_wake",   {15'h0, ifc.wake},    16'h0);
      check("t5_async_vec_id", {13'h0, ifc.vec_id},  16'h0);
      rd("t5_async_con", 3'd0, 8'h00);
      rd("t5_async_ie",  3'd1, 8'h00);
      rd("t5_async_if",  3'd2, 8'h00);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) tick();
      rd("t5_no_spurious", 3'd2, 8'h00);

      // Event-to-IF latency
      ifc.src_in = 4'b1011;
      for (int k = 0; k < LAT - 1; k++) begin
         tick();
         rd("lat_early", 3'd2, 8'h00);
      end
      tick();
      rd("lat_if1", 3'd2, 8'h02);

      // Falling-edge polarity on source 0
      ifc2.src_in = 4'b0000;
      for (int k = 0; k < LAT; k++) tick();
      ifc2.reg_addr = 3'd2;
      #1;
      check("fall_if0", {8'h00, ifc2.reg_rdata}, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
